// File: rtl/spmm_out_drain.sv
// spmm_out_drain: double-buffered collector for SpMM result rows.
// Rows from the PE array fill the write bank one per cycle; a committed
// bank is drained to the host as 4-row blocks, one block per cycle.
module spmm_out_drain #(
   parameter int N = 16,
   parameter int W = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         row_valid,
   input  logic [$clog2(N)-1:0]         row_idx,
   input  logic [N-1:0][W-1:0]          row_data,
   input  logic                         row_last,
   output logic                         in_ready,
   output logic                         out_ready,
   input  logic                         out_start,
   output logic                         out_valid,
   output logic [3:0][N-1:0][W-1:0]     out_data,
   output int                           num_el
);

   localparam int AW = $clog2(N);
   localparam int BW = (N > 4) ? $clog2(N / 4) : 1;
   localparam logic [BW-1:0] LAST_BLK = BW'(N / 4 - 1);

   typedef logic [W-1:0]              data_t;
   typedef data_t [N-1:0]             row_t;
   typedef row_t [3:0]                blk_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READY,
      S_DRAIN
   } state_t;

   // Bank storage; never cleared, validity comes from the written bitmap.
   row_t          mem [2][N];
   logic [N-1:0]  written [2];
   logic [1:0]    full;
   logic          wr_bank;
   logic          rd_bank;
   state_t        state;
   logic [BW-1:0] blk;
   logic          accept;

   assign in_ready = !full[wr_bank];
   assign accept   = row_valid && in_ready;
   assign num_el   = N;

   // Gather rows 4k..4k+3 of bank b; rows never written read as zero.
   function automatic blk_t rd_block(input logic b, input logic [BW-1:0] k);
      blk_t          blk_o;
      logic [AW-1:0] r;
      blk_o = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         r = AW'(k * 4 + i);
         if (written[b][r]) begin
            blk_o[i[1:0]] = mem[b][r];
         end
      end
      return blk_o;
   endfunction

   // Row storage write port for the current write bank.
   always_ff @(posedge clock) begin
      if (accept) begin
         mem[wr_bank][row_idx] <= row_data;
      end
   end

   // Bank bookkeeping plus drain FSM with registered host-side outputs.
   // Commit and release always target different banks (the write bank is
   // only the read bank while that bank is full, i.e. while writes stall),
   // so both may update written/full at the same edge without conflict.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         written[0] <= '0;
         written[1] <= '0;
         full       <= '0;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         state      <= S_IDLE;
         blk        <= '0;
         out_ready  <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         if (accept) begin
            written[wr_bank][row_idx] <= 1'b1;
            if (row_last) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
            end
         end

         case (state)
            S_IDLE: begin
               out_valid <= 1'b0;
               out_data  <= '0;
               if (full[rd_bank]) begin
                  state     <= S_READY;
                  out_ready <= 1'b1;
               end else begin
                  out_ready <= 1'b0;
               end
            end

            S_READY: begin
               if (out_start) begin
                  state     <= S_DRAIN;
                  blk       <= '0;
                  out_ready <= 1'b0;
                  out_valid <= 1'b1;
                  out_data  <= rd_block(rd_bank, '0);
               end
            end

            S_DRAIN: begin
               if (blk == LAST_BLK) begin
                  full[rd_bank]    <= 1'b0;
                  written[rd_bank] <= '0;
                  rd_bank          <= ~rd_bank;
                  state            <= S_IDLE;
                  out_valid        <= 1'b0;
                  out_data         <= '0;
               end else begin
                  blk      <= blk + 1'b1;
                  out_data <= rd_block(rd_bank, blk + 1'b1);
               end
            end

            default: begin
               state     <= S_IDLE;
               out_ready <= 1'b0;
               out_valid <= 1'b0;
               out_data  <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/spmm_out_drain.md
# spmm_out_drain

Double-buffered result collector sitting directly downstream of the SpMM PE array. It accepts one finished output row of the N×N product per cycle and holds each complete matrix in one of two banks. It then drains a committed matrix to the host four rows per cycle over the `out_ready`/`out_start` handshake. Ping-ponging the two banks lets the PE array fill the next matrix while the previous one is being drained.

## Interface
Parameters:
- `N`, 16: matrix dimension; must be a multiple of 4 and a power of two.
- `W`, 8: element width, in bits, of `data_t`.

Ports:
- `clock`, in, 1: the single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `row_valid`, in, 1: `row_data` holds a result row this cycle.
- `row_idx`, in, $clog2(N): destination row index within the matrix.
- `row_data`, in, N×W (`data_t [N-1:0]`): one result row; element j is column j.
- `row_last`, in, 1: qualifies `row_valid`; the accepted row is the final row of the matrix and commits the write bank.
- `in_ready`, out, 1: the write bank is free and rows are accepted.
- `out_ready`, out, 1: a committed bank is waiting to be drained.
- `out_start`, in, 1: the host requests a drain; honoured only while `out_ready` is high.
- `out_valid`, out, 1: `out_data` carries a valid 4-row block.
- `out_data`, out, 4×N×W (`data_t [3:0][N-1:0]`): rows 4k..4k+3 of the drained matrix; entry [i][j] is row 4k+i, column j.
- `num_el`, out, int: constant N.

## Operation
- **State.**
  - Two banks, each N×N×W.
  - Per bank, an N-bit `written` bitmap and a `full` flag.
  - A `wr_bank` pointer and an `rd_bank` pointer, both 1 bit.
  - Drain FSM state and a $clog2(N/4)-bit block counter `blk`.
- **Write side.**
  - `in_ready` = !`full[wr_bank]`.
  - Accept = `row_valid` && `in_ready`. On accept, row `row_idx` of bank `wr_bank` gets `row_data` and `written[row_idx]` is set.
  - A repeated `row_idx` before commit overwrites the row; last write wins.
  - `row_valid` while `in_ready` is low is ignored, with no state change.
  - Accept with `row_last`: the row is written, `full[wr_bank]` is set, and `wr_bank` toggles, all at the same edge.
  - Rows whose `written` bit is clear drain as all-zero; the bank memory is not cleared.
- **Drain FSM.**
  - **IDLE** → **READY** when `full[rd_bank]`.
  - **READY**: `out_ready`=1. On `out_start`, set `blk`=0 and go to **DRAIN**.
  - **DRAIN**: `out_valid`=1 and `out_data` = rows 4·`blk`..4·`blk`+3 of `rd_bank`. `blk` increments each cycle.
  - When `blk` = N/4−1, the same edge clears `full[rd_bank]` and the `written` bitmap of `rd_bank`, toggles `rd_bank`, and returns to **IDLE**.
- **Ignored `out_start`.** `out_start` in IDLE or DRAIN is ignored and never queued.
- **Output values.**
  - `out_data` is all-zero whenever `out_valid`=0.
  - `out_ready`=0 outside READY.
- **Arithmetic.** None on data; values pass through unmodified at W bits.
- **Reset.** Immediate on `reset` rise, including mid-fill or mid-drain:
  - both banks become empty;
  - `wr_bank`=`rd_bank`=0;
  - FSM goes to IDLE;
  - outputs: `in_ready`=1, `out_ready`=0, `out_valid`=0, `out_data`=0, `num_el`=N.
  - Partially filled or partially drained matrices are discarded.

## Timing
- **Write latency.** A row accepted at edge t becomes visible to a drain that starts at or after t+1.
- **Commit to ready.** `row_last` accepted at edge t gives `full` at t, the FSM enters READY at t+1, and `out_ready` is high during cycle t+1..
- **Handshake to data.** `out_start` sampled high with `out_ready` at edge s:
  - `out_ready` is low from cycle s+1;
  - `out_valid` is high for cycles s+1..s+N/4, block k appearing in cycle s+1+k;
  - drain throughput is 4 rows per cycle, N/4 cycles per matrix.
- **Bank release.**
  - The bank frees at the edge that ends the last drain cycle.
  - If the write side was stalled on that bank, `in_ready` rises in the next cycle.
  - If the other bank is already full, `out_ready` reasserts one cycle after the return to IDLE. There is a minimum one idle cycle between drains.
- **Simultaneous events.** A commit of the write bank at the same edge that the drain frees the read bank is legal. Both take effect, and `wr_bank`/`rd_bank` toggle independently.
- **Both banks full.** `in_ready`=0 until the drain completes.
- **Fill while draining.** Filling the other bank during DRAIN is unaffected by the drain.

## Test plan
- **Single matrix round-trip.** N=16; write rows 0..15 with row r, col c = r·16+c (mod 256), `row_last` on row 15, then pulse `out_start` in the first READY cycle. Expect `out_ready` one cycle after commit. Expect 4 `out_valid` cycles with block k = rows 4k..4k+3 exact, then `out_ready`=0.
- **Sparse fill.** Write only rows 2 and 9 (value 0x5A), then `row_last` on row 9. Expect drained rows 2 and 9 all 0x5A and every other row 0x00.
- **Ping-pong overlap.**
  - Commit matrix A (all 0x11).
  - During A's drain, fill matrix B (all 0x22) with commit.
  - Expect `in_ready` to stay 1 during the overlap.
  - Expect B's `out_ready` two cycles after A's last block; B drains 0x22 only.
- **Backpressure.** Commit A and B without draining. Expect `in_ready`=0, and a third `row_valid` (0x33) to be dropped. Drain A, then B. Expect no 0x33 anywhere, and `in_ready`=1 the cycle after A's drain ends.
- **Ignored start and reset.**
  - Pulse `out_start` while IDLE: expect no `out_valid`.
  - Pulse `out_start` again during DRAIN: expect the drain length still N/4.
  - Assert `reset` mid-drain (block 1): expect `out_valid`, `out_ready` and `out_data` to be 0 immediately, and `in_ready`=1.
  - After reset, a fresh single matrix drains correctly.
